// File: rtl/bist_misr_analyzer.sv
// Output response analyser for a BIST loop: compacts CUT responses into a Galois MISR and,
// after NUM_PATTERNS accepted vectors, compares the signature against GOLDEN.
module bist_misr_analyzer #(
  parameter int unsigned           WIDTH        = 3,
  parameter logic [WIDTH-1:0]      POLY         = 3'b010,
  parameter logic [WIDTH-1:0]      SEED         = 3'b000,
  parameter int unsigned           NUM_PATTERNS = 7,
  parameter logic [WIDTH-1:0]      GOLDEN       = 3'b010
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  output logic [WIDTH-1:0] Signature,
  output logic             Busy,
  output logic             Done,
  output logic             Pass
);

  localparam int unsigned CntW = $clog2(NUM_PATTERNS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCompact,
    StCompare,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [CntW-1:0]  count_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             fb;

  // Galois shift right with feedback from the LSB, then fold in the response vector
  always_comb begin
    fb    = sig_q[0];
    sig_d = {fb, sig_q[WIDTH-1:1]} ^ (POLY & {WIDTH{fb}}) ^ Din;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      sig_q   <= SEED;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            state_q <= StCompact;
            sig_q   <= SEED;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        StCompact: begin
          // A restart wins over a vector presented in the same cycle
          if (Start) begin
            sig_q   <= SEED;
            count_q <= '0;
          end else if (Din_valid) begin
            sig_q <= sig_d;
            if (count_q == LastCnt) begin
              state_q <= StCompare;
            end else begin
              count_q <= count_q + CntW'(1);
            end
          end
        end
        StCompare: begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (sig_q == GOLDEN);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Signature = sig_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Pass      = pass_q;

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Scoreboard bench for bist_misr_analyzer: stimulus pushes expected signatures/results,
// a monitor pops and compares whenever the DUT accepts a vector or raises Done.
module tb_bist_misr_analyzer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Start = 1'b0;
  logic [2:0] Din = 3'b000;
  logic       Din_valid = 1'b0;
  logic [2:0] Signature;
  logic       Busy;
  logic       Done;
  logic       Pass;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_sig_q[$];
  logic [3:0] exp_res_q[$];  // {signature, pass}

  logic [2:0] gold_din [7] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [2:0] gold_sig [7] = '{3'b001, 3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010};
  logic [2:0] fault_din[7] = '{3'b001, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 3'b000};
  logic [2:0] fault_sig[7] = '{3'b001, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001, 3'b110};

  bist_misr_analyzer dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .Din       (Din),
    .Din_valid (Din_valid),
    .Signature (Signature),
    .Busy      (Busy),
    .Done      (Done),
    .Pass      (Pass)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs are driven on negedge, so values read here are those seen by the edge
  always @(posedge CLK) begin
    logic s_start, s_valid, s_busy, s_done;
    logic [2:0] e;
    logic [3:0] r;
    logic [2:0] last_exp;
    s_start = Start;
    s_valid = Din_valid;
    s_busy  = Busy;
    s_done  = Done;
    #1;
    if (RST) begin
      if (s_start) begin
        check("start_sig", Signature, 3'b000);
        check("start_busy", Busy, 1'b1);
        check("start_done", Done, 1'b0);
        check("start_pass", Pass, 1'b0);
        last_exp = 3'b000;
      end else if (s_busy && s_valid) begin
        if (exp_sig_q.size() == 0) begin
          check("unexpected_vector", 1'b1, 1'b0);
        end else begin
          e = exp_sig_q.pop_front();
          check("trace_sig", Signature, e);
          last_exp = e;
        end
      end else if (s_busy) begin
        check("hold_sig", Signature, last_exp);
      end
      if (!s_done && Done) begin
        if (exp_res_q.size() == 0) begin
          check("unexpected_done", 1'b1, 1'b0);
        end else begin
          r = exp_res_q.pop_front();
          check("final_sig", Signature, r[3:1]);
          check("final_pass", Pass, r[0]);
        end
      end
    end
  end

  task automatic do_start(input logic junk_valid);
    @(negedge CLK);
    Start     = 1'b1;
    Din_valid = junk_valid;
    Din       = 3'b111;
  endtask

  task automatic send(input logic [2:0] d, input logic [2:0] s);
    @(negedge CLK);
    Start     = 1'b0;
    Din       = d;
    Din_valid = 1'b1;
    exp_sig_q.push_back(s);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge CLK);
      Start     = 1'b0;
      Din_valid = 1'b0;
      Din       = 3'b101;
    end
  endtask

  task automatic run_session(input bit fault, input bit stall, input bit with_start);
    logic exp_pass;
    exp_pass = !fault;
    if (with_start) do_start(1'b0);
    for (int i = 0; i < 7; i++) begin
      if (stall && i > 0) gap((i % 3) + 1);
      send(fault ? fault_din[i] : gold_din[i], fault ? fault_sig[i] : gold_sig[i]);
      if (i == 6) exp_res_q.push_back({fault ? fault_sig[6] : gold_sig[6], exp_pass});
    end
    gap(1);  // after edge k: compare still in progress
    check("done_early", Done, 1'b0);
    check("busy_compare", Busy, 1'b1);
    gap(1);  // after edge k+1
    check("done_latency", Done, 1'b1);
    check("pass_latency", Pass, exp_pass);
    check("busy_done", Busy, 1'b0);
    gap(2);
    check("done_hold", Done, 1'b1);
    check("sig_hold_done", Signature, fault ? fault_sig[6] : gold_sig[6]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_sig", Signature, 3'b000);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_pass", Pass, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    gap(2);
    check("idle_busy", Busy, 1'b0);

    // Golden run
    run_session(1'b0, 1'b0, 1'b1);
    // Re-arm from DONE, second golden run
    run_session(1'b0, 1'b0, 1'b1);
    // Fault on vector 4
    run_session(1'b1, 1'b0, 1'b1);
    // Stalls between vectors
    run_session(1'b0, 1'b1, 1'b1);

    // Restart after 3 vectors; Din presented with the restart is dropped
    do_start(1'b0);
    for (int i = 0; i < 3; i++) send(gold_din[i], gold_sig[i]);
    do_start(1'b1);
    run_session(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-COMPACT
    do_start(1'b0);
    for (int i = 0; i < 3; i++) send(gold_din[i], gold_sig[i]);
    @(negedge CLK);
    Din_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    check("async_rst_sig", Signature, 3'b000);
    check("async_rst_busy", Busy, 1'b0);
    check("async_rst_done", Done, 1'b0);
    check("async_rst_pass", Pass, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    gap(10);
    check("no_done_after_abort", Done, 1'b0);
    check("idle_after_abort", Busy, 1'b0);
    check("sig_queue_empty", exp_sig_q.size(), 0);
    check("res_queue_empty", exp_res_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
